// File: rtl/bcd_to_binary_seq.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble), one bit per clock.
// Optional invalid-digit detection is enabled by defining BCD_DIGIT_CHECK_EN.
module bcd_to_binary_seq #(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_out,
    output logic                  err
);

    localparam int BCD_W  = 4 * N_DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CNT_W  = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state;
    logic [WORK_W-1:0]  work;
    logic [CNT_W-1:0]   cnt;
    logic [WORK_W-1:0]  corrected;
    logic               last_shift;
    logic               digit_bad;

    assign last_shift = (cnt == CNT_W'(BIN_W - 1));

    // Shift right once, then pull every BCD field that reached 8 or more back down by 3.
    always_comb begin
        logic [WORK_W-1:0] shifted;
        logic [3:0]        field;
        // NOTE: every variable gets a value before any branch so no latch is inferred.
        shifted   = work >> 1;
        corrected = shifted;
        field     = 4'd0;
        for (int k = 0; k < N_DIGITS; k++) begin
            field = shifted[BIN_W + 4*k +: 4];
            if (field >= 4'd8) begin
                corrected[BIN_W + 4*k +: 4] = field - 4'd3;
            end
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    always_comb begin
        digit_bad = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (bcd_in[4*k +: 4] > 4'd9) begin
                digit_bad = 1'b1;
            end
        end
    end
`else
    assign digit_bad = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the work register is a plain datapath register, so it is reset like all other state.
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= '0;
            err     <= 1'b0;
            work    <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start && digit_bad) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bin_out <= '0;
                        err     <= 1'b1;
                    end else if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        work  <= {bcd_in, {BIN_W{1'b0}}};
                        cnt   <= '0;
                        err   <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                SHIFT: begin
                    work <= corrected;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_shift) begin
                        state   <= DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        bin_out <= corrected[BIN_W-1:0];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Directed self-checking bench for bcd_to_binary_seq: latency, handshake, reset abort,
// optional digit check and a strided sweep of 0000..9999 against a decimal model.
module tb_bcd_to_binary_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] bin_out;
    logic        err;

    int total;
    int bad;

    bcd_to_binary_seq #(.N_DIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal reference: build the packed BCD of a value by digit extraction.
    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    // Issue start, then wait (bounded) for done; returns in the DONE cycle.
    task automatic convert(input string tag, input logic [15:0] bcd, input logic [13:0] exp_bin,
                           input logic exp_err, input int exp_lat);
        int lat;
        start  = 1'b1;
        bcd_in = bcd;
        tick();
        start  = 1'b0;
        bcd_in = 16'hFFFF;
        check({tag, " busy_after_accept"}, {31'd0, busy}, {31'd0, (exp_lat != 0)});
        lat = 0;
        while (!done && lat < 40) begin
            if (busy && done) check({tag, " busy_done_overlap"}, 32'd1, 32'd0);
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " bin_out"}, {18'd0, bin_out}, {18'd0, exp_bin});
        check({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
        check({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 16'h0000;
        tick();
        tick();
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset bin_out", {18'd0, bin_out}, 32'd0);
        check("reset err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Largest value, then done must drop after one cycle with start low.
        convert("9999", 16'h9999, 14'h270F, 1'b0, 14);
        tick();
        check("9999 done_one_cycle", {31'd0, done}, 32'd0);
        check("9999 bin_out_held", {18'd0, bin_out}, 32'h270F);

        // Back-to-back: second start is driven during DONE, no idle gap.
        convert("0000", 16'h0000, 14'd0, 1'b0, 14);
        convert("1234", 16'h1234, 14'h04D2, 1'b0, 14);
        tick();

        // Start re-pulsed mid-conversion is ignored.
        start  = 1'b1;
        bcd_in = 16'h0042;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        start  = 1'b1;
        bcd_in = 16'h9999;
        tick();
        start  = 1'b0;
        check("0042 busy_after_restart", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 9; i++) tick();
        check("0042 done", {31'd0, done}, 32'd1);
        check("0042 bin_out", {18'd0, bin_out}, 32'd42);
        tick();
        check("0042 single_done", {31'd0, done}, 32'd0);
        check("0042 idle_busy", {31'd0, busy}, 32'd0);

        // Asynchronous reset mid-conversion.
        start  = 1'b1;
        bcd_in = 16'h5678;
        tick();
        start  = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        #1;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        check("abort bin_out", {18'd0, bin_out}, 32'd0);
        check("abort err", {31'd0, err}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        convert("5678", 16'h5678, 14'd5678, 1'b0, 14);
        tick();

`ifdef BCD_DIGIT_CHECK_EN
        convert("12A4", 16'h12A4, 14'd0, 1'b1, 0);
        convert("0007", 16'h0007, 14'd7, 1'b0, 14);
        tick();
`endif

        // Strided sweep against the decimal model, back-to-back.
        for (int v = 0; v <= 9999; v += 37) begin
            convert($sformatf("sweep %0d", v), to_bcd(v), 14'(v), 1'b0, 14);
        end
        convert("sweep 9998", to_bcd(9998), 14'd9998, 1'b0, 14);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
